// File: rtl/change_dispenser.sv
// Coin payout controller: pays a latched change amount largest-coin-first (25/10/5),
// pulsing one eject solenoid per coin and waiting for the sensor acknowledge.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] change_cents,
  input  logic       coin_sensed,
  input  logic       clear_fault,
  output logic       eject_25,
  output logic       eject_10,
  output logic       eject_5,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [3:0] count_25,
  output logic [3:0] count_10,
  output logic [3:0] count_5
);

  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT} state_e;
  typedef enum logic [1:0] {COIN_25, COIN_10, COIN_5} coin_e;

  state_e        state_q, state_d;
  coin_e         sel_q, sel_d;
  logic [7:0]    rem_q, rem_d;
  logic [3:0]    c25_q, c25_d;
  logic [3:0]    c10_q, c10_d;
  logic [3:0]    c5_q, c5_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ej25_q, ej10_q, ej5_q;
  logic          busy_q, done_q, fault_q;
  logic          amount_ok;

  function automatic logic [7:0] coin_value(input coin_e c);
    case (c)
      COIN_25: return 8'd25;
      COIN_10: return 8'd10;
      default: return 8'd5;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign amount_ok = ((change_cents % 8'd5) == 8'd0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    c25_d   = c25_q;
    c10_d   = c10_q;
    c5_d    = c5_q;
    pcnt_d  = pcnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = change_cents;
          c25_d   = '0;
          c10_d   = '0;
          c5_d    = '0;
          state_d = amount_ok ? SELECT : FAULT;
        end
      end
      SELECT: begin
        if (rem_q == 8'd0) begin
          state_d = DONE;
        end else begin
          if (rem_q >= 8'd25)      sel_d = COIN_25;
          else if (rem_q >= 8'd10) sel_d = COIN_10;
          else                     sel_d = COIN_5;
          pcnt_d  = PW'(PULSE_CYCLES - 1);
          state_d = EJECT;
        end
      end
      EJECT: begin
        if (pcnt_q == '0) begin
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      WAIT_ACK: begin
        // Acknowledge takes priority over a timeout landing on the same edge.
        if (coin_sensed) begin
          rem_d = rem_q - coin_value(sel_q);
          case (sel_q)
            COIN_25: c25_d = sat_inc(c25_q);
            COIN_10: c10_d = sat_inc(c10_q);
            default: c5_d  = sat_inc(c5_q);
          endcase
          state_d = SELECT;
        end else if (tmo_q == TW'(ACK_TIMEOUT)) begin
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   if (clear_fault) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Eject and done follow the current state, so they lag the state register by one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= COIN_25;
      rem_q   <= '0;
      c25_q   <= '0;
      c10_q   <= '0;
      c5_q    <= '0;
      pcnt_q  <= '0;
      tmo_q   <= '0;
      ej25_q  <= 1'b0;
      ej10_q  <= 1'b0;
      ej5_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      c25_q   <= c25_d;
      c10_q   <= c10_d;
      c5_q    <= c5_d;
      pcnt_q  <= pcnt_d;
      tmo_q   <= tmo_d;
      ej25_q  <= (state_q == EJECT) && (sel_q == COIN_25);
      ej10_q  <= (state_q == EJECT) && (sel_q == COIN_10);
      ej5_q   <= (state_q == EJECT) && (sel_q == COIN_5);
      busy_q  <= state_d inside {SELECT, EJECT, WAIT_ACK, DONE};
      done_q  <= (state_q == DONE);
      fault_q <= (state_d == FAULT);
    end
  end

  assign eject_25  = ej25_q;
  assign eject_10  = ej10_q;
  assign eject_5   = ej5_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = rem_q;
  assign count_25  = c25_q;
  assign count_10  = c10_q;
  assign count_5   = c5_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout order, zero change, bad amount,
// ack timeout, ignored inputs during payout, and asynchronous reset mid-eject.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] change_cents = 8'd0;
  logic       coin_sensed = 1'b0;
  logic       clear_fault = 1'b0;
  logic       eject_25, eject_10, eject_5;
  logic       busy, done, fault;
  logic [7:0] remaining;
  logic [3:0] count_25, count_10, count_5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  change_dispenser #(
    .PULSE_CYCLES(4),
    .ACK_TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .change_cents(change_cents),
    .coin_sensed (coin_sensed),
    .clear_fault (clear_fault),
    .eject_25    (eject_25),
    .eject_10    (eject_10),
    .eject_5     (eject_5),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .remaining   (remaining),
    .count_25    (count_25),
    .count_10    (count_10),
    .count_5     (count_5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ejects();
    return {29'd0, eject_25, eject_10, eject_5};
  endfunction

  function automatic logic [31:0] all_outs();
    return {6'd0, eject_25, eject_10, eject_5, busy, done, fault,
            remaining, count_25, count_10, count_5};
  endfunction

  // Entered just after the edge that put the block in SELECT; ends just after the ack edge.
  task automatic coin_cycle(input logic [2:0] ej, input logic [7:0] rem,
                            input logic [3:0] c25, input logic [3:0] c10,
                            input logic [3:0] c5, input bit disturb);
    tick();
    chk("select_no_eject", ejects(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (disturb && i == 1) begin
        start        = 1'b1;
        change_cents = 8'd5;
        coin_sensed  = 1'b1;
      end
      tick();
      start       = 1'b0;
      coin_sensed = 1'b0;
      chk("eject_on", ejects(), {29'd0, ej});
      chk("busy_in_eject", {31'd0, busy}, 32'd1);
    end
    tick();
    chk("eject_off", ejects(), 32'd0);
    tick();
    tick();
    coin_sensed = 1'b1;
    tick();
    coin_sensed = 1'b0;
    chk("remaining", {24'd0, remaining}, {24'd0, rem});
    chk("counts", {20'd0, count_25, count_10, count_5}, {20'd0, c25, c10, c5});
  endtask

  task automatic done_seq();
    tick();
    chk("pre_done", {30'd0, busy, done}, 32'b10);
    tick();
    chk("done_pulse", {30'd0, busy, done}, 32'b01);
    tick();
    chk("after_done", {30'd0, busy, done}, 32'b00);
  endtask

  task automatic do_start(input logic [7:0] cents);
    change_cents = cents;
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 32'd0);

    // 40 cents: 25, 10, 5
    do_start(8'd40);
    chk("t1_busy_at_N", {31'd0, busy}, 32'd1);
    chk("t1_loaded", {24'd0, remaining}, 32'd40);
    coin_cycle(3'b100, 8'd15, 4'd1, 4'd0, 4'd0, 1'b0);
    coin_cycle(3'b010, 8'd5,  4'd1, 4'd1, 4'd0, 1'b0);
    coin_cycle(3'b001, 8'd0,  4'd1, 4'd1, 4'd1, 1'b0);
    done_seq();
    tick();
    chk("t1_idle_hold", {20'd0, count_25, count_10, count_5}, 32'h111);

    // Zero change
    do_start(8'd0);
    chk("t2_busy_N", {30'd0, busy, done}, 32'b10);
    done_seq();
    chk("t2_no_eject", ejects(), 32'd0);
    chk("t2_counts_cleared", {20'd0, count_25, count_10, count_5}, 32'd0);

    // Bad amount, clear with simultaneous start
    do_start(8'd7);
    chk("t3_fault", {29'd0, fault, busy, done}, 32'b100);
    chk("t3_rem", {24'd0, remaining}, 32'd7);
    tick();
    tick();
    chk("t3_no_eject", ejects(), 32'd0);
    chk("t3_fault_held", {31'd0, fault}, 32'd1);
    change_cents = 8'd25;
    start        = 1'b1;
    clear_fault  = 1'b1;
    tick();
    start       = 1'b0;
    clear_fault = 1'b0;
    chk("t3_cleared", {30'd0, fault, busy}, 32'b00);
    tick();
    chk("t3_start_dropped", {30'd0, busy, fault}, 32'b00);
    do_start(8'd10);
    coin_cycle(3'b010, 8'd0, 4'd0, 4'd1, 4'd0, 1'b0);
    done_seq();

    // Ack timeout
    do_start(8'd25);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("t4_eject_on", ejects(), 32'b100);
    tick();
    chk("t4_eject_off", ejects(), 32'd0);
    for (int i = 0; i < 19; i++) tick();
    chk("t4_no_fault_19", {31'd0, fault}, 32'd0);
    tick();
    chk("t4_fault_20", {30'd0, fault, busy}, 32'b10);
    chk("t4_frozen", {20'd0, remaining, count_25}, {20'd0, 8'd25, 4'd0});
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("t4_clear", {31'd0, fault}, 32'd0);

    // 55 cents with stray start and coin_sensed during eject
    do_start(8'd55);
    coin_cycle(3'b100, 8'd30, 4'd1, 4'd0, 4'd0, 1'b1);
    coin_cycle(3'b100, 8'd5,  4'd2, 4'd0, 4'd0, 1'b0);
    coin_cycle(3'b001, 8'd0,  4'd2, 4'd0, 4'd1, 1'b0);
    done_seq();

    // Reset during second cycle of eject_10
    do_start(8'd10);
    tick();
    tick();
    tick();
    chk("t6_eject_10", ejects(), 32'b010);
    reset_n = 1'b0;
    #1;
    chk("t6_async_clear", all_outs(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t6_idle", all_outs(), 32'd0);
    do_start(8'd5);
    coin_cycle(3'b001, 8'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    done_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream of the vending FSM. On a start pulse it latches the change amount in cents (the FSM's Rtotal, binary) and pays it out coin by coin, largest coin first (25, 10, 5). Each coin is a timed eject pulse, and the block then waits for the coin-sensor acknowledge. It reports progress (remaining amount, per-coin counts) for the 7-segment and LED path, and raises a fault on a bad amount or a missing coin.

Parameters:
PULSE_CYCLES, 4, clock cycles each eject output is held high (>=1)
ACK_TIMEOUT, 1000000, cycles to wait for coin_sensed after eject pulse ends before fault (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: begin payout of change_cents
change_cents  input  8  change to return, binary cents, 0..255
coin_sensed  input  1  single-cycle pulse from coin sensor, one per coin delivered
clear_fault  input  1  single-cycle pulse: leave FAULT
eject_25  output  1  quarter eject solenoid drive
eject_10  output  1  dime eject solenoid drive
eject_5  output  1  nickel eject solenoid drive
busy  output  1  high from the cycle after start is accepted until DONE completes
done  output  1  one-cycle pulse when payout is complete
fault  output  1  high while in FAULT
remaining  output  8  cents still to pay
count_25  output  4  quarters paid this transaction
count_10  output  4  dimes paid this transaction
count_5  output  4  nickels paid this transaction

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; internal counters 0.
- States: IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT. All outputs are registered.
- IDLE: start=1 at edge N loads remaining<=change_cents and clears count_25/10/5.
  - change_cents%5==0: go to SELECT; busy=1 from N.
  - otherwise: go to FAULT.
  - start is ignored in every other state. count_* and remaining hold their last values while in IDLE.
- SELECT (one cycle):
  - remaining==0: go to DONE.
  - remaining>=25: select the 25 coin. Else remaining>=10: select 10. Else select 5.
  - Go to EJECT and load the pulse counter.
- EJECT: the selected eject_* is high for exactly PULSE_CYCLES cycles, starting at the edge after the SELECT cycle. At most one eject_* is high at any time. Then go to WAIT_ACK and load the timeout counter.
- WAIT_ACK:
  - coin_sensed=1: remaining <= remaining - coin value; the matching count_* increments (saturates at 15); go to SELECT.
  - Timeout counter reaches ACK_TIMEOUT with no coin_sensed: go to FAULT; remaining and count_* are frozen.
  - coin_sensed in any other state is ignored.
- DONE: done=1 for one cycle, busy=0 at the next edge, then IDLE.
- FAULT: fault=1, busy=0, all eject_*=0. Stays in FAULT until clear_fault=1, then IDLE (fault drops at the next edge). start is ignored in FAULT.
- Arithmetic: 8-bit unsigned. Subtraction never underflows, because the coin selection guarantees coin value <= remaining.
- Latency, zero change: start at edge N, SELECT at N+1, done high in the cycle after N+2.
- Latency, nonzero change: the first eject rises at edge N+2.
- Simultaneous start and clear_fault in FAULT: clear_fault wins; start is dropped.
- Reset mid-eject: eject drops asynchronously and the transaction is abandoned.

Test Plan:
1. change_cents=40, start, coin_sensed 3 cycles after each eject falls:
   - required: eject_25, then eject_10, then eject_5, each high 4 cycles;
   - required: remaining goes 40→15→5→0; counts end 1/1/1; done pulses once; busy low afterwards.
2. change_cents=0, start at edge N:
   - required: no eject; done high exactly one cycle after edge N+2; busy high 2 cycles.
3. change_cents=7, start:
   - required: fault=1 next cycle; no eject; clear_fault returns to IDLE; a subsequent start with 10 pays one dime.
4. ACK_TIMEOUT=20, change_cents=25, coin_sensed never asserted:
   - required: fault rises 20 cycles after eject_25 falls; remaining stays 25; count_25 stays 0.
5. During a 55-cent payout, pulse start (change_cents=5) and an extra coin_sensed during EJECT:
   - required: both are ignored; sequence is 25,25,5; counts end 2/0/1.
6. Assert reset_n=0 during the 2nd cycle of eject_10:
   - required: all outputs 0 immediately; after release, the block is in IDLE and accepts a new start.
